// File: rtl/obi_mem_pkg.sv
// Shared types and helpers for the OBI memory responder.
package obi_mem_pkg;

   localparam int unsigned MaxLatency = 4;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_resp_t;

   // True when addr falls inside [base, base + words*4). The limit is
   // computed in 33 bits so a window ending at 2**32 does not wrap.
   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned words);
      logic [32:0] limit;
      limit = {1'b0, base} + {words[30:0], 2'b00};
      return (addr >= base) && ({1'b0, addr} < limit);
   endfunction

endpackage

// File: rtl/obi_resp_delay.sv
// Fixed-latency shift register carrying responses from grant to rvalid.
module obi_resp_delay
   import obi_mem_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      in_valid,
   input  obi_resp_t in_resp,
   output logic      out_valid,
   output obi_resp_t out_resp
);

   logic [Depth-1:0]      valid;
   obi_resp_t [Depth-1:0] data;

   // Shift one stage per cycle; reset drops everything in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         data  <= '0;
      end else begin
         valid[0] <= in_valid;
         data[0]  <= in_valid ? in_resp : '0;
         for (int i = 1; i < Depth; i++) begin
            valid[i] <= valid[i-1];
            data[i]  <= data[i-1];
         end
      end
   end

   assign out_valid = valid[Depth-1];
   assign out_resp  = data[Depth-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder backed by a word-addressed flop memory with fixed latency.
module obi_mem_responder
   import obi_mem_pkg::*;
#(
   parameter int unsigned NumWords       = 256,
   parameter logic [31:0] BaseAddr       = 32'h1000_0000,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned IdxW = $clog2(NumWords);
   localparam int unsigned CntW = $clog2(MaxLatency + 2);

   logic [31:0]     mem [NumWords];
   logic [CntW-1:0] outstanding;
   logic [31:0]     offset;
   logic [IdxW-1:0] idx;
   logic            hit;
   logic            hs;
   obi_resp_t       resp_in;
   obi_resp_t       resp_out;
   logic            unused_offset;

   assign offset        = addr_i - BaseAddr;
   assign idx           = offset[IdxW+1:2];
   assign unused_offset = ^{offset[31:IdxW+2], offset[1:0]};
   assign hit           = addr_hit(addr_i, BaseAddr, NumWords);

   // A response leaving the pipe this cycle frees its slot immediately.
   assign gnt_o = req_i & ~stall_i & ~rst_i &
                  ((outstanding < CntW'(MaxOutstanding)) | rvalid_o);
   assign hs    = req_i & gnt_o;

   // Byte-masked write on a handshake hit; memory is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (hs && we_i && hit) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
   end

   // Build the response at grant time: read data, write ack, or decode error.
   always_comb begin
      resp_in = '0;
      if (!hit)       resp_in.err   = 1'b1;
      else if (!we_i) resp_in.rdata = mem[idx];
   end

   obi_resp_delay #(
      .Depth (RespLatency)
   ) u_delay (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (hs),
      .in_resp   (resp_in),
      .out_valid (rvalid_o),
      .out_resp  (resp_out)
   );

   assign rdata_o = rvalid_o ? resp_out.rdata : '0;
   assign err_o   = rvalid_o & resp_out.err;

   // Track granted-but-unanswered requests.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else begin
         case ({hs, rvalid_o})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Counter bounds hold by construction of the grant rule.
   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
                               outstanding <= CntW'(MaxOutstanding));
   a_cnt_min: assert property (@(posedge clk_i) disable iff (rst_i)
                               !(rvalid_o && !hs && outstanding == '0));

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench with a queue-based reference model of the responder.
module tb_obi_mem_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          NW   = 256;
   localparam int          LAT  = 3;
   localparam int          MO   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rec   = 1'b0;

   typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
   typedef struct { int cyc; logic [31:0] rdata; logic err; } log_t;

   exp_t        q[$];
   log_t        rlog[$];
   bit          gnt_hist[$];
   logic [31:0] mmem [NW];

   obi_mem_responder #(
      .NumWords       (NW),
      .BaseAddr       (BASE),
      .RespLatency    (LAT),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .stall_i  (stall),
      .req_i    (req),
      .gnt_o    (gnt),
      .addr_i   (addr),
      .we_i     (we),
      .be_i     (be),
      .wdata_i  (wdata),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .err_o    (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model, evaluated mid-cycle every cycle.
   always @(negedge clk) begin
      bit          exp_rv;
      bit          exp_gnt;
      longint      a;
      int          widx;
      exp_t        e;
      if (rst) begin
         q.delete();
         check("gnt_in_reset", {31'b0, gnt}, 32'd0);
         check("rvalid_in_reset", {31'b0, rvalid}, 32'd0);
         check("rdata_in_reset", rdata, 32'd0);
         check("err_in_reset", {31'b0, err}, 32'd0);
      end else begin
         exp_rv  = (q.size() > 0) && (q[0].due == cyc);
         exp_gnt = req && !stall && ((q.size() < MO) || exp_rv);
         check("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
         check("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
         check("rdata", rdata, exp_rv ? q[0].rdata : 32'd0);
         check("err", {31'b0, err}, exp_rv ? {31'b0, q[0].err} : 32'd0);
         if (rvalid) rlog.push_back('{cyc, rdata, err});
         if (rec) gnt_hist.push_back(gnt);
         if (exp_rv) void'(q.pop_front());
         if (req && exp_gnt) begin
            a = longint'(addr) - longint'(BASE);
            e.due = cyc + LAT;
            e.rdata = '0;
            e.err = 1'b0;
            if (a < 0 || a >= NW * 4) begin
               e.err = 1'b1;
            end else begin
               widx = int'(a / 4);
               if (we) begin
                  for (int k = 0; k < 4; k++)
                     if (be[k]) mmem[widx][8*k +: 8] = wdata[8*k +: 8];
               end else begin
                  e.rdata = mmem[widx];
               end
            end
            q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int gcyc);
      bit got;
      got = 1'b0;
      gcyc = -1;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (gnt) begin
            got = 1'b1;
            gcyc = cyc;
         end else begin
            step();
         end
      end
      if (!got) check("grant_timeout", 32'd0, 32'd1);
      step();
      req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
      step();
   endtask

   initial begin
      int g0, g1, n0;
      logic [31:0] seq_off [8];
      logic [31:0] seq_dat [8];
      logic [5:0]  gpat;

      req = 1'b1;
      addr = BASE;
      repeat (3) step();
      rst = 1'b0;
      req = 1'b0;
      step();

      // Full write then read back.
      do_req(1'b1, BASE + 8, 4'hF, 32'hDEADBEEF, g0);
      do_req(1'b0, BASE + 8, 4'h0, 32'h0, g1);
      drain();
      check("wr_resp_rdata", rlog[rlog.size()-2].rdata, 32'h0);
      check("wr_resp_err", {31'b0, rlog[rlog.size()-2].err}, 32'd0);
      check("rd_rdata", rlog[rlog.size()-1].rdata, 32'hDEADBEEF);
      check("rd_err", {31'b0, rlog[rlog.size()-1].err}, 32'd0);
      check("rd_latency", 32'(rlog[rlog.size()-1].cyc - g1), 32'd3);
      check("wr_latency", 32'(rlog[rlog.size()-2].cyc - g0), 32'd3);

      // Partial write merge.
      do_req(1'b1, BASE + 16, 4'hF, 32'h11223344, g0);
      do_req(1'b1, BASE + 16, 4'b0010, 32'h0000AB00, g0);
      do_req(1'b1, BASE + 16, 4'b0000, 32'hFFFFFFFF, g0);
      do_req(1'b0, BASE + 16, 4'h0, 32'h0, g0);
      drain();
      check("partial_write", rlog[rlog.size()-1].rdata, 32'h1122AB44);

      // Out-of-range accesses, then confirm word 0 survived.
      do_req(1'b1, BASE, 4'hF, 32'hA5A50001, g0);
      do_req(1'b0, BASE + NW * 4, 4'h0, 32'h0, g0);
      do_req(1'b1, BASE + NW * 4, 4'hF, 32'hFFFFFFFF, g0);
      do_req(1'b0, BASE - 4, 4'h0, 32'h0, g0);
      do_req(1'b0, BASE, 4'h0, 32'h0, g0);
      drain();
      check("oob_rd_err", {31'b0, rlog[rlog.size()-4].err}, 32'd1);
      check("oob_rd_rdata", rlog[rlog.size()-4].rdata, 32'h0);
      check("oob_wr_err", {31'b0, rlog[rlog.size()-3].err}, 32'd1);
      check("below_base_err", {31'b0, rlog[rlog.size()-2].err}, 32'd1);
      check("word0_intact", rlog[rlog.size()-1].rdata, 32'hA5A50001);

      // Eight continuous reads: grant throttled by the outstanding limit.
      seq_off = '{0, 8, 16, 0, 8, 16, 0, 8};
      seq_dat = '{32'hA5A50001, 32'hDEADBEEF, 32'h1122AB44, 32'hA5A50001,
                  32'hDEADBEEF, 32'h1122AB44, 32'hA5A50001, 32'hDEADBEEF};
      n0 = rlog.size();
      gnt_hist.delete();
      rec = 1'b1;
      for (int i = 0; i < 8; i++) do_req(1'b0, BASE + seq_off[i], 4'h0, 32'h0, g0);
      rec = 1'b0;
      drain();
      check("burst_count", 32'(rlog.size() - n0), 32'd8);
      for (int i = 0; i < 8; i++)
         if (n0 + i < rlog.size()) check("burst_order", rlog[n0+i].rdata, seq_dat[i]);
      if (gnt_hist.size() >= 6) begin
         gpat = {gnt_hist[0], gnt_hist[1], gnt_hist[2], gnt_hist[3], gnt_hist[4], gnt_hist[5]};
         check("gnt_pattern", {26'b0, gpat}, {26'b0, 6'b110110});
      end else begin
         check("gnt_hist_len", 32'(gnt_hist.size()), 32'd6);
      end

      // Stall with one response in flight.
      do_req(1'b0, BASE + 16, 4'h0, 32'h0, g0);
      stall = 1'b1;
      req = 1'b1; we = 1'b0; addr = BASE; be = 4'h0;
      repeat (5) begin
         @(negedge clk);
         check("stall_gnt", {31'b0, gnt}, 32'd0);
         step();
      end
      check("inflight_during_stall", rlog[rlog.size()-1].rdata, 32'h1122AB44);
      stall = 1'b0;
      @(negedge clk);
      check("gnt_on_stall_drop", {31'b0, gnt}, 32'd1);
      step();
      req = 1'b0;
      drain();
      check("post_stall_rdata", rlog[rlog.size()-1].rdata, 32'hA5A50001);

      // Reset with two reads in flight.
      n0 = rlog.size();
      do_req(1'b0, BASE + 8, 4'h0, 32'h0, g0);
      do_req(1'b0, BASE + 16, 4'h0, 32'h0, g1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (8) step();
      check("no_resp_after_reset", 32'(rlog.size() - n0), 32'd0);
      do_req(1'b0, BASE + 8, 4'h0, 32'h0, g0);
      drain();
      check("read_after_reset", rlog[rlog.size()-1].rdata, 32'hDEADBEEF);
      check("read_after_reset_lat", 32'(rlog[rlog.size()-1].cyc - g0), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
